// File: rtl/rtc_clock_core.sv
// ============================================================================
// Module   : rtc_clock_core
// Purpose  : Time-of-day core (h/m/s) with tick prescaler, validated load,
//            manual bumps, minute alarm and 12/24h BCD display digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_clock_core #(
    parameter int INIT_HOUR     = 0,
    parameter int INIT_MIN      = 0,
    parameter int INIT_SEC      = 0,
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode_12h,
    input  logic       set_valid,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic       set_err,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic       alarm_fire,
    output logic       sec_pulse,
    output logic       day_wrap,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       pm,
    output logic [3:0] Ht,
    output logic [3:0] Hu,
    output logic [3:0] Mt,
    output logic [3:0] Mu,
    output logic [3:0] St,
    output logic [3:0] Su
);

    localparam int c_CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TICKS_PER_SEC - 1);

    if (INIT_HOUR < 0 || INIT_HOUR > 23) begin : g_bad_init_hour
        $error("rtc_clock_core: INIT_HOUR out of range 0..23");
    end
    if (INIT_MIN < 0 || INIT_MIN > 59) begin : g_bad_init_min
        $error("rtc_clock_core: INIT_MIN out of range 0..59");
    end
    if (INIT_SEC < 0 || INIT_SEC > 59) begin : g_bad_init_sec
        $error("rtc_clock_core: INIT_SEC out of range 0..59");
    end
    if (TICKS_PER_SEC < 1) begin : g_bad_tps
        $error("rtc_clock_core: TICKS_PER_SEC must be >= 1");
    end

    logic [4:0]         r_hour;
    logic [5:0]         r_min;
    logic [5:0]         r_sec;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_set_err;
    logic               r_alarm_fire;
    logic               r_sec_pulse;
    logic               r_day_wrap;

    logic       w_advance;
    logic       w_set_ok;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic       w_hour_wrap;
    logic [5:0] w_adv_sec;
    logic [5:0] w_adv_min;
    logic [4:0] w_adv_hour;
    logic       w_alarm_hit;
    logic [4:0] w_disp_hour;
    logic [7:0] w_h_bcd;
    logic [7:0] w_m_bcd;
    logic [7:0] w_s_bcd;

    // Range-compare BCD split for 0..59; avoids a divider
    function automatic logic [7:0] f_to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] u;
        if (v >= 6'd50) begin
            t = 4'd5; u = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            t = 4'd4; u = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            t = 4'd3; u = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            t = 4'd2; u = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            t = 4'd1; u = 4'(v - 6'd10);
        end else begin
            t = 4'd0; u = v[3:0];
        end
        return {t, u};
    endfunction

    assign w_advance   = tick && (r_cnt == c_CNT_MAX);
    assign w_set_ok    = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
    assign w_sec_wrap  = (r_sec == 6'd59);
    assign w_min_wrap  = (r_min == 6'd59);
    assign w_hour_wrap = (r_hour == 5'd23);

    assign w_adv_sec  = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    assign w_adv_min  = w_sec_wrap ? (w_min_wrap ? 6'd0 : r_min + 6'd1) : r_min;
    assign w_adv_hour = (w_sec_wrap && w_min_wrap) ? (w_hour_wrap ? 5'd0 : r_hour + 5'd1) : r_hour;

    // The advanced second is zero exactly when the current second wraps
    assign w_alarm_hit = alarm_en && w_sec_wrap &&
                         (alarm_hour == w_adv_hour) && (alarm_min == w_adv_min);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hour       <= 5'(INIT_HOUR);
            r_min        <= 6'(INIT_MIN);
            r_sec        <= 6'(INIT_SEC);
            r_cnt        <= '0;
            r_set_err    <= 1'b0;
            r_alarm_fire <= 1'b0;
            r_sec_pulse  <= 1'b0;
            r_day_wrap   <= 1'b0;
        end else begin
            r_set_err    <= 1'b0;
            r_alarm_fire <= 1'b0;
            r_sec_pulse  <= 1'b0;
            r_day_wrap   <= 1'b0;

            if (tick) begin
                r_cnt <= w_advance ? '0 : r_cnt + 1'b1;
            end

            if (set_valid) begin
                if (w_set_ok) begin
                    r_hour <= set_hour;
                    r_min  <= set_min;
                    r_sec  <= set_sec;
                    r_cnt  <= '0;
                end else begin
                    r_set_err <= 1'b1;
                end
            end else if (inc_hour || inc_min) begin
                if (inc_min) begin
                    r_min <= w_min_wrap ? 6'd0 : r_min + 6'd1;
                    r_sec <= 6'd0;
                end
                if (inc_hour) begin
                    r_hour <= w_hour_wrap ? 5'd0 : r_hour + 5'd1;
                end
            end else if (w_advance) begin
                r_sec        <= w_adv_sec;
                r_min        <= w_adv_min;
                r_hour       <= w_adv_hour;
                r_sec_pulse  <= 1'b1;
                r_day_wrap   <= w_sec_wrap && w_min_wrap && w_hour_wrap;
                r_alarm_fire <= w_alarm_hit;
            end
        end
    end

    always_comb begin
        w_disp_hour = r_hour;
        if (mode_12h) begin
            if (r_hour == 5'd0) begin
                w_disp_hour = 5'd12;
            end else if (r_hour > 5'd12) begin
                w_disp_hour = r_hour - 5'd12;
            end
        end
    end

    assign w_h_bcd = f_to_bcd({1'b0, w_disp_hour});
    assign w_m_bcd = f_to_bcd(r_min);
    assign w_s_bcd = f_to_bcd(r_sec);

    assign hour       = r_hour;
    assign min        = r_min;
    assign sec        = r_sec;
    assign set_err    = r_set_err;
    assign alarm_fire = r_alarm_fire;
    assign sec_pulse  = r_sec_pulse;
    assign day_wrap   = r_day_wrap;
    assign pm         = mode_12h && (r_hour >= 5'd12);
    assign Ht         = w_h_bcd[7:4];
    assign Hu         = w_h_bcd[3:0];
    assign Mt         = w_m_bcd[7:4];
    assign Mu         = w_m_bcd[3:0];
    assign St         = w_s_bcd[7:4];
    assign Su         = w_s_bcd[3:0];

endmodule

`default_nettype wire

// File: tb/tb_rtc_clock_core.sv
// ============================================================================
// Module   : tb_rtc_clock_core
// Purpose  : Self-checking bench for rtc_clock_core (TPS=1 and TPS=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtc_clock_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick, mode_12h, set_valid, inc_hour, inc_min, alarm_en;
    logic [4:0] set_hour, alarm_hour;
    logic [5:0] set_min, set_sec, alarm_min;

    logic [4:0] hour_o [2];
    logic [5:0] min_o  [2];
    logic [5:0] sec_o  [2];
    logic [3:0] ht_o [2], hu_o [2], mt_o [2], mu_o [2], st_o [2], su_o [2];
    logic       pm_o [2], err_o [2], fire_o [2], sp_o [2], dw_o [2];

    int checks = 0;
    int errors = 0;

    int tps    [2] = '{1, 4};
    int init_t [2] = '{23*3600 + 59*60 + 58, 10*3600 + 20*60 + 30};

    // Reference model: time as seconds-of-day plus prescaler count
    int m_t [2], m_cnt [2];
    bit m_err [2], m_fire [2], m_sp [2], m_dw [2];

    rtc_clock_core #(.INIT_HOUR(23), .INIT_MIN(59), .INIT_SEC(58), .TICKS_PER_SEC(1)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .mode_12h(mode_12h),
        .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_err(err_o[0]), .inc_hour(inc_hour), .inc_min(inc_min),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_fire(fire_o[0]), .sec_pulse(sp_o[0]), .day_wrap(dw_o[0]),
        .hour(hour_o[0]), .min(min_o[0]), .sec(sec_o[0]), .pm(pm_o[0]),
        .Ht(ht_o[0]), .Hu(hu_o[0]), .Mt(mt_o[0]), .Mu(mu_o[0]), .St(st_o[0]), .Su(su_o[0])
    );

    rtc_clock_core #(.INIT_HOUR(10), .INIT_MIN(20), .INIT_SEC(30), .TICKS_PER_SEC(4)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .mode_12h(mode_12h),
        .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_err(err_o[1]), .inc_hour(inc_hour), .inc_min(inc_min),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_fire(fire_o[1]), .sec_pulse(sp_o[1]), .day_wrap(dw_o[1]),
        .hour(hour_o[1]), .min(min_o[1]), .sec(sec_o[1]), .pm(pm_o[1]),
        .Ht(ht_o[1]), .Hu(hu_o[1]), .Mt(mt_o[1]), .Mu(mu_o[1]), .St(st_o[1]), .Su(su_o[1])
    );

    // One clock edge: update the model from the inputs seen at the edge
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int  h, m, s;
            bit  adv;
            m_err[k] = 0; m_fire[k] = 0; m_sp[k] = 0; m_dw[k] = 0;
            if (rst) begin
                m_t[k]   = init_t[k];
                m_cnt[k] = 0;
            end else begin
                adv = 0;
                if (tick) begin
                    if (m_cnt[k] == tps[k] - 1) begin
                        m_cnt[k] = 0;
                        adv      = 1;
                    end else begin
                        m_cnt[k]++;
                    end
                end
                h = m_t[k] / 3600; m = (m_t[k] / 60) % 60; s = m_t[k] % 60;
                if (set_valid) begin
                    if (set_hour < 24 && set_min < 60 && set_sec < 60) begin
                        m_t[k]   = set_hour * 3600 + set_min * 60 + set_sec;
                        m_cnt[k] = 0;
                    end else begin
                        m_err[k] = 1;
                    end
                end else if (inc_hour || inc_min) begin
                    if (inc_min) begin
                        m = (m + 1) % 60;
                        s = 0;
                    end
                    if (inc_hour) h = (h + 1) % 24;
                    m_t[k] = h * 3600 + m * 60 + s;
                end else if (adv) begin
                    m_dw[k]   = (m_t[k] == 86399);
                    m_t[k]    = (m_t[k] + 1) % 86400;
                    m_sp[k]   = 1;
                    m_fire[k] = alarm_en && (m_t[k] % 60 == 0) &&
                                (m_t[k] / 3600 == alarm_hour) && ((m_t[k] / 60) % 60 == alarm_min);
                end
            end
        end
        #1;
    endtask

    function automatic logic [45:0] exp_vec(input int k);
        int h, m, s, d;
        h = m_t[k] / 3600; m = (m_t[k] / 60) % 60; s = m_t[k] % 60;
        d = mode_12h ? ((h == 0) ? 12 : (h > 12 ? h - 12 : h)) : h;
        return {5'(h), 6'(m), 6'(s), 4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), (mode_12h && h >= 12),
                m_err[k], m_fire[k], m_sp[k], m_dw[k]};
    endfunction

    function automatic logic [45:0] got_vec(input int k);
        return {hour_o[k], min_o[k], sec_o[k], ht_o[k], hu_o[k], mt_o[k], mu_o[k],
                st_o[k], su_o[k], pm_o[k], err_o[k], fire_o[k], sp_o[k], dw_o[k]};
    endfunction

    task automatic do_set(input int h, input int m, input int s);
        set_valid = 1; set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
        step();
        set_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; step(); step(); rst = 0;
        checks++;
        if ({hour_o[0], min_o[0], sec_o[0]} !== {5'd23, 6'd59, 6'd58}) begin
            errors++; $display("FAIL reset_time0 got %0d:%0d:%0d exp 23:59:58", hour_o[0], min_o[0], sec_o[0]);
        end
        checks++;
        if ({hour_o[1], min_o[1], sec_o[1]} !== {5'd10, 6'd20, 6'd30}) begin
            errors++; $display("FAIL reset_time1 got %0d:%0d:%0d exp 10:20:30", hour_o[1], min_o[1], sec_o[1]);
        end
        checks++;
        if ({err_o[0], fire_o[0], sp_o[0], dw_o[0], err_o[1], fire_o[1], sp_o[1], dw_o[1]} !== 8'd0) begin
            errors++; $display("FAIL reset_pulses got nonzero pulse exp 0");
        end
        checks++;
        if ({ht_o[0], hu_o[0], pm_o[0]} !== {4'd2, 4'd3, 1'b0}) begin
            errors++; $display("FAIL reset_disp24 got %0d%0d pm=%0d exp 23 pm=0", ht_o[0], hu_o[0], pm_o[0]);
        end
    endtask

    task automatic test_rollover();
        tick = 1; step();
        checks++;
        if ({hour_o[0], min_o[0], sec_o[0], sp_o[0], dw_o[0]} !== {5'd23, 6'd59, 6'd59, 1'b1, 1'b0}) begin
            errors++; $display("FAIL roll_first got %0d:%0d:%0d sp=%0d dw=%0d exp 23:59:59 sp=1 dw=0",
                               hour_o[0], min_o[0], sec_o[0], sp_o[0], dw_o[0]);
        end
        step();
        checks++;
        if ({hour_o[0], min_o[0], sec_o[0], sp_o[0], dw_o[0]} !== {5'd0, 6'd0, 6'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL roll_wrap got %0d:%0d:%0d sp=%0d dw=%0d exp 0:0:0 sp=1 dw=1",
                               hour_o[0], min_o[0], sec_o[0], sp_o[0], dw_o[0]);
        end
        tick = 0; step();
        checks++;
        if ({sp_o[0], dw_o[0], sec_o[0]} !== {1'b0, 1'b0, 6'd0}) begin
            errors++; $display("FAIL roll_after got sp=%0d dw=%0d sec=%0d exp 0 0 0", sp_o[0], dw_o[0], sec_o[0]);
        end
    endtask

    task automatic test_prescale();
        rst = 1; step(); rst = 0;
        for (int i = 1; i <= 8; i++) begin
            tick = 1; step();
            checks++;
            if (sp_o[1] !== ((i % 4) == 0)) begin
                errors++; $display("FAIL prescale_tick%0d got sp=%0d exp %0d", i, sp_o[1], (i % 4) == 0);
            end
            tick = 0; step();
            checks++;
            if (sp_o[1] !== 1'b0) begin
                errors++; $display("FAIL prescale_idle%0d got sp=%0d exp 0", i, sp_o[1]);
            end
        end
        checks++;
        if ({hour_o[1], min_o[1], sec_o[1]} !== {5'd10, 6'd20, 6'd32}) begin
            errors++; $display("FAIL prescale_time got %0d:%0d:%0d exp 10:20:32", hour_o[1], min_o[1], sec_o[1]);
        end
    endtask

    task automatic test_set();
        rst = 1; step(); rst = 0;
        do_set(24, 0, 0);
        checks++;
        if ({err_o[0], hour_o[0], min_o[0], sec_o[0]} !== {1'b1, 5'd23, 6'd59, 6'd58}) begin
            errors++; $display("FAIL set_reject got err=%0d %0d:%0d:%0d exp err=1 23:59:58",
                               err_o[0], hour_o[0], min_o[0], sec_o[0]);
        end
        step();
        checks++;
        if (err_o[0] !== 1'b0) begin
            errors++; $display("FAIL set_err_pulse got %0d exp 0", err_o[0]);
        end
        tick = 1; do_set(13, 5, 30); tick = 0;
        checks++;
        if ({err_o[0], sp_o[0], hour_o[0], min_o[0], sec_o[0]} !== {1'b0, 1'b0, 5'd13, 6'd5, 6'd30}) begin
            errors++; $display("FAIL set_load got err=%0d sp=%0d %0d:%0d:%0d exp 0 0 13:5:30",
                               err_o[0], sp_o[0], hour_o[0], min_o[0], sec_o[0]);
        end
        mode_12h = 1; #1;
        checks++;
        if ({ht_o[0], hu_o[0], pm_o[0], mt_o[0], mu_o[0], st_o[0], su_o[0]} !==
            {4'd0, 4'd1, 1'b1, 4'd0, 4'd5, 4'd3, 4'd0}) begin
            errors++; $display("FAIL disp12 got %0d%0d pm=%0d %0d%0d %0d%0d exp 01 pm=1 05 30",
                               ht_o[0], hu_o[0], pm_o[0], mt_o[0], mu_o[0], st_o[0], su_o[0]);
        end
        mode_12h = 0; #1;
        checks++;
        if ({ht_o[0], hu_o[0], pm_o[0]} !== {4'd1, 4'd3, 1'b0}) begin
            errors++; $display("FAIL disp24 got %0d%0d pm=%0d exp 13 pm=0", ht_o[0], hu_o[0], pm_o[0]);
        end
    endtask

    task automatic test_alarm();
        alarm_en = 1; alarm_hour = 5'd7; alarm_min = 6'd0;
        do_set(6, 59, 59);
        tick = 1; step(); tick = 0;
        checks++;
        if ({fire_o[0], hour_o[0], min_o[0], sec_o[0]} !== {1'b1, 5'd7, 6'd0, 6'd0}) begin
            errors++; $display("FAIL alarm_fire got fire=%0d %0d:%0d:%0d exp 1 7:0:0",
                               fire_o[0], hour_o[0], min_o[0], sec_o[0]);
        end
        step();
        checks++;
        if (fire_o[0] !== 1'b0) begin
            errors++; $display("FAIL alarm_pulse got %0d exp 0", fire_o[0]);
        end
        do_set(6, 59, 10);
        inc_min = 1; step(); inc_min = 0;
        checks++;
        if ({fire_o[0], hour_o[0], min_o[0], sec_o[0]} !== {1'b0, 5'd6, 6'd0, 6'd0}) begin
            errors++; $display("FAIL alarm_inc got fire=%0d %0d:%0d:%0d exp 0 6:0:0",
                               fire_o[0], hour_o[0], min_o[0], sec_o[0]);
        end
    endtask

    task automatic test_inc_both();
        do_set(23, 59, 40);
        inc_hour = 1; inc_min = 1; tick = 1; step();
        inc_hour = 0; inc_min = 0; tick = 0;
        checks++;
        if ({dw_o[0], sp_o[0], hour_o[0], min_o[0], sec_o[0]} !== {1'b0, 1'b0, 5'd0, 6'd0, 6'd0}) begin
            errors++; $display("FAIL inc_both got dw=%0d sp=%0d %0d:%0d:%0d exp 0 0 0:0:0",
                               dw_o[0], sp_o[0], hour_o[0], min_o[0], sec_o[0]);
        end
    endtask

    task automatic test_rst_mid();
        do_set(23, 59, 59);
        rst = 1; tick = 1; set_valid = 1; set_hour = 5'd30; step();
        rst = 0; tick = 0; set_valid = 0;
        checks++;
        if ({hour_o[0], min_o[0], sec_o[0], err_o[0], fire_o[0], sp_o[0], dw_o[0]} !==
            {5'd23, 6'd59, 6'd58, 4'd0}) begin
            errors++; $display("FAIL rst_mid got %0d:%0d:%0d pulses=%b exp 23:59:58 0000",
                               hour_o[0], min_o[0], sec_o[0], {err_o[0], fire_o[0], sp_o[0], dw_o[0]});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            tick      = 1'($urandom_range(0, 1));
            set_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) begin
                set_hour = 5'($urandom_range(0, 26));
                set_min  = 6'($urandom_range(0, 63));
                set_sec  = 6'($urandom_range(0, 63));
            end else begin
                set_hour = 5'd23; set_min = 6'd59; set_sec = 6'($urandom_range(50, 59));
            end
            inc_hour = ($urandom_range(0, 15) == 0);
            inc_min  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) mode_12h = ~mode_12h;
            alarm_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) begin
                alarm_hour = 5'(m_t[0] / 3600);
                alarm_min  = 6'(((m_t[0] / 60) + 1) % 60);
            end else if ($urandom_range(0, 99) == 0) begin
                alarm_hour = 5'($urandom_range(24, 31));
            end
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random[%0d] n=%0d got %h exp %h", k, n, got_vec(k), exp_vec(k));
                end
            end
        end
        rst = 0; tick = 0; set_valid = 0; inc_hour = 0; inc_min = 0;
    endtask

    initial begin
        rst = 1; tick = 0; mode_12h = 0; set_valid = 0; inc_hour = 0; inc_min = 0;
        alarm_en = 0; set_hour = '0; set_min = '0; set_sec = '0;
        alarm_hour = 5'd31; alarm_min = '0;
        test_reset();
        test_rollover();
        test_prescale();
        test_set();
        test_alarm();
        test_inc_both();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
